prbs8_checker: RTL and testbench

PRBS8_CHECKER -- requirements
Module: prbs8_checker

---
 rtl/prbs8_checker.sv | 122 ++++++++++++
 tb/tb_prbs8_checker.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/prbs8_checker.sv
// PRBS8 receive checker: acquires lock on a x^8+x^7+x^6+x^5+1 style word stream,
// flywheels the prediction while locked and counts mismatched words.
module prbs8_checker #(
  parameter int LOCK_CNT   = 8,
  parameter int UNLOCK_CNT = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       data_in,
  input  logic             valid_in,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int RUN_W  = $clog2(LOCK_CNT + 1);
  localparam int MISS_W = $clog2(UNLOCK_CNT + 1);

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  state_t             state_q;
  logic [7:0]         pred_q;
  logic [RUN_W-1:0]   run_q;
  logic [MISS_W-1:0]  miss_q;
  logic               locked_q;
  logic               err_pulse_q;
  logic [CNT_W-1:0]   err_cnt_q;
  logic [CNT_W-1:0]   err_cnt_d;

  logic               word_match;
  logic               err_in;
  logic [RUN_W-1:0]   run_inc;
  logic [MISS_W-1:0]  miss_inc;

  function automatic logic [7:0] nxt(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[6] ^ s[5] ^ s[4]};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // The all-zero word is never a legal sequence member, so it never matches.
  assign word_match = (data_in != 8'h00) && (data_in == pred_q);
  assign err_in     = valid_in && (state_q == LOCKED) && !word_match;
  assign run_inc    = run_q + RUN_W'(1);
  assign miss_inc   = miss_q + MISS_W'(1);

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (clr_cnt)     err_cnt_d = CNT_W'(err_in);
    else if (err_in) err_cnt_d = sat_inc(err_cnt_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SEARCH;
      pred_q      <= 8'h00;
      run_q       <= '0;
      miss_q      <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      err_pulse_q <= err_in;
      err_cnt_q   <= err_cnt_d;
      if (valid_in) begin
        case (state_q)
          SEARCH: begin
            if (data_in != 8'h00) begin
              pred_q  <= nxt(data_in);
              run_q   <= RUN_W'(1);
              state_q <= VERIFY;
            end
          end
          VERIFY: begin
            if (data_in == 8'h00) begin
              run_q   <= '0;
              state_q <= SEARCH;
            end else if (word_match) begin
              pred_q <= nxt(data_in);
              run_q  <= run_inc;
              if (run_inc == RUN_W'(LOCK_CNT)) begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
                miss_q   <= '0;
              end
            end else begin
              pred_q <= nxt(data_in);
              run_q  <= RUN_W'(1);
            end
          end
          LOCKED: begin
            if (word_match) begin
              pred_q <= nxt(data_in);
              miss_q <= '0;
            end else begin
              // Flywheel: a corrupted word must not reseed the prediction.
              pred_q <= nxt(pred_q);
              if (miss_inc == MISS_W'(UNLOCK_CNT)) begin
                state_q  <= SEARCH;
                locked_q <= 1'b0;
                miss_q   <= '0;
                run_q    <= '0;
              end else begin
                miss_q <= miss_inc;
              end
            end
          end
          default: state_q <= SEARCH;
        endcase
      end
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_prbs8_checker.sv
// Directed bench for prbs8_checker: one default instance and one with a 4-bit error counter.
module tb_prbs8_checker;

  logic        clk;
  logic        rst_n;
  logic [7:0]  data_in;
  logic        valid_in;
  logic        clr_cnt;
  logic        locked, err_pulse;
  logic [15:0] err_cnt;
  logic        locked4, err_pulse4;
  logic [3:0]  err_cnt4;

  int checks;
  int errors;
  logic [7:0] exp_w;

  prbs8_checker dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .valid_in(valid_in),
    .clr_cnt(clr_cnt), .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt)
  );

  prbs8_checker #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .valid_in(valid_in),
    .clr_cnt(clr_cnt), .locked(locked4), .err_pulse(err_pulse4), .err_cnt(err_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] nxt(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[6] ^ s[5] ^ s[4]};
  endfunction

  task automatic send(input logic [7:0] d, input logic v, input logic clr);
    @(negedge clk);
    data_in  = d;
    valid_in = v;
    clr_cnt  = clr;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    clr_cnt  = 1'b0;
  endtask

  task automatic send_clean(input int n);
    for (int i = 0; i < n; i++) begin
      send(exp_w, 1'b1, 1'b0);
      exp_w = nxt(exp_w);
    end
  endtask

  task automatic send_err();
    send(8'h00, 1'b1, 1'b0);
    exp_w = nxt(exp_w);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_w = 8'h01;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    data_in = 8'h01;
    valid_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %b want 0", locked); end
    checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse got %b want 0", err_pulse); end
    checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", err_cnt); end
    valid_in = 1'b0;
    do_reset();
  endtask

  task automatic test_lock();
    do_reset();
    send(8'h01, 1'b1, 1'b0); send(8'h02, 1'b1, 1'b0); send(8'h04, 1'b1, 1'b0);
    send(8'h08, 1'b1, 1'b0); send(8'h10, 1'b1, 1'b0); send(8'h21, 1'b1, 1'b0);
    send(8'h43, 1'b1, 1'b0);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lock_early got %b want 0", locked); end
    send(8'h87, 1'b1, 1'b0);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_8th got %b want 1", locked); end
    checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL lock_cnt got %0d want 0", err_cnt); end
    exp_w = 8'h0F;
  endtask

  task automatic test_single_err();
    send(8'hFF, 1'b1, 1'b0);
    exp_w = nxt(exp_w);
    checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL single_pulse got %b want 1", err_pulse); end
    checks++; if (err_cnt !== 16'd1) begin errors++; $display("FAIL single_cnt got %0d want 1", err_cnt); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL single_locked got %b want 1", locked); end
    send(8'h1E, 1'b1, 1'b0);
    exp_w = 8'h3D;
    checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL flywheel_pulse got %b want 0", err_pulse); end
    checks++; if (err_cnt !== 16'd1) begin errors++; $display("FAIL flywheel_cnt got %0d want 1", err_cnt); end
    send_clean(1);
    checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL flywheel2_pulse got %b want 0", err_pulse); end
  endtask

  task automatic test_unlock();
    send_err(); send_err(); send_err();
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL unlock_3rd got %b want 1", locked); end
    send_err();
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL unlock_4th got %b want 0", locked); end
    checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL unlock_pulse got %b want 1", err_pulse); end
    checks++; if (err_cnt !== 16'd5) begin errors++; $display("FAIL unlock_cnt got %0d want 5", err_cnt); end
    send(8'h00, 1'b0, 1'b0);
    checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL pulse_width got %b want 0", err_pulse); end
    send(8'h00, 1'b1, 1'b0);
    checks++; if (err_cnt !== 16'd5) begin errors++; $display("FAIL search_no_count got %0d want 5", err_cnt); end
    exp_w = 8'h55;
    send_clean(7);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL relock_early got %b want 0", locked); end
    send_clean(1);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL relock got %b want 1", locked); end
    checks++; if (err_cnt !== 16'd5) begin errors++; $display("FAIL relock_cnt got %0d want 5", err_cnt); end
  endtask

  task automatic test_zero_and_gaps();
    do_reset();
    for (int i = 0; i < 5; i++) send(8'h00, 1'b1, 1'b0);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL zeros_locked got %b want 0", locked); end
    checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL zeros_cnt got %0d want 0", err_cnt); end
    for (int i = 0; i < 8; i++) begin
      send(8'hAA, 1'b0, 1'b0);
      if (i == 7) begin
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL gap_locked got %b want 0", locked); end
      end
      send_clean(1);
    end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL gap_lock got %b want 1", locked); end
    // Zero word in VERIFY restarts the count.
    do_reset();
    send_clean(5);
    send(8'h00, 1'b1, 1'b0);
    send_clean(7);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL zero_restart got %b want 0", locked); end
    send_clean(1);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL zero_restart_lock got %b want 1", locked); end
    // Nonzero mismatch in VERIFY reseeds and counts as 1.
    do_reset();
    send_clean(5);
    exp_w = 8'h55;
    send_clean(7);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reseed_early got %b want 0", locked); end
    send_clean(1);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL reseed_lock got %b want 1", locked); end
  endtask

  task automatic test_saturation();
    do_reset();
    send_clean(8);
    for (int g = 0; g < 6; g++) begin
      send_err(); send_err(); send_err();
      send_clean(1);
    end
    send_err(); send_err();
    send_clean(1);
    checks++; if (locked4 !== 1'b1) begin errors++; $display("FAIL sat_locked got %b want 1", locked4); end
    checks++; if (err_cnt4 !== 4'hF) begin errors++; $display("FAIL sat_cnt4 got %h want f", err_cnt4); end
    checks++; if (err_cnt !== 16'd20) begin errors++; $display("FAIL sat_cnt16 got %0d want 20", err_cnt); end
    send(8'h00, 1'b1, 1'b1);
    exp_w = nxt(exp_w);
    checks++; if (err_cnt4 !== 4'h1) begin errors++; $display("FAIL clr_err4 got %h want 1", err_cnt4); end
    checks++; if (err_cnt !== 16'd1) begin errors++; $display("FAIL clr_err16 got %0d want 1", err_cnt); end
    send(exp_w, 1'b1, 1'b1);
    exp_w = nxt(exp_w);
    checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL clr_match got %0d want 0", err_cnt); end
    checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL clr_match_pulse got %b want 0", err_pulse); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_clean(8);
    send_err(); send_err(); send_err();
    send_clean(1);
    send_err(); send_err();
    checks++; if (err_cnt !== 16'd5) begin errors++; $display("FAIL mid_cnt got %0d want 5", err_cnt); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL mid_rst_locked got %b want 0", locked); end
    checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL mid_rst_cnt got %0d want 0", err_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    exp_w = 8'h01;
    send_clean(7);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reacq_early got %b want 0", locked); end
    send_clean(1);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL reacq got %b want 1", locked); end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    data_in  = 8'h00;
    valid_in = 1'b0;
    clr_cnt  = 1'b0;
    exp_w    = 8'h01;
    test_reset();
    test_lock();
    test_single_err();
    test_unlock();
    test_zero_and_gaps();
    test_saturation();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
